sha256_msg_schedule: RTL and testbench

//  - SHA-256 message-schedule stage. Directly upstream of the compression/hash-round stage.
//  - Takes one padded 512-bit block and emits W[0..63] as a valid/ready word stream, one word per cycle.
//  - Optionally also assembles the full 2048-bit W vector for a consumer that indexes W by round.

---
 rtl/sha256_pkg.sv | 23 ++
 rtl/sha256_msg_schedule_if.sv | 38 +++
 rtl/sha256_sched_word.sv | 15 +
 rtl/sha256_msg_schedule.sv | 110 +++++++++++
 tb/tb_sha256_msg_schedule.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/block sizes, schedule FSM states and the
// small-sigma functions used by both the message schedule and the round stage.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLOCK_W   = 512;
  localparam int unsigned WK_LENGTH = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-load and word-stream signals of the SHA-256 message schedule.
// Optional W-vector signals exist only when SHA_WVEC_OUT_EN is defined.
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic                 start;
  logic [BLOCK_W-1:0]   block_in;
  logic                 in_ready;
  logic                 w_valid;
  logic                 w_ready;
  logic [WORD_W-1:0]    w_out;
  logic [5:0]           w_index;
  logic                 w_last;
  logic                 done;
`ifdef SHA_WVEC_OUT_EN
  logic [WK_LENGTH*WORD_W-1:0] w_vector;
  logic                        w_vector_ok;

  modport master (
    output start, block_in, w_ready,
    input  in_ready, w_valid, w_out, w_index, w_last, done, w_vector, w_vector_ok
  );
  modport slave (
    input  start, block_in, w_ready,
    output in_ready, w_valid, w_out, w_index, w_last, done, w_vector, w_vector_ok
  );
`else
  modport master (
    output start, block_in, w_ready,
    input  in_ready, w_valid, w_out, w_index, w_last, done
  );
  modport slave (
    input  start, block_in, w_ready,
    output in_ready, w_valid, w_out, w_index, w_last, done
  );
`endif

endinterface

// File: rtl/sha256_sched_word.sv
// Combinational next schedule word from four taps of the 16-word window:
// W[t+16] = sig1(W[t+14]) + W[t+9] + sig0(W[t+1]) + W[t], mod 2^32.
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] i_w14,
  input  logic [WORD_W-1:0] i_w9,
  input  logic [WORD_W-1:0] i_w1,
  input  logic [WORD_W-1:0] i_w0,
  output logic [WORD_W-1:0] o_w16
);

  assign o_w16 = sig1(i_w14) + i_w9 + sig0(i_w1) + i_w0;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams W[0..63] one word
// per handshake. Optional macro SHA_WVEC_OUT_EN also assembles the 2048-bit W vector.
module sha256_msg_schedule #(
  parameter int unsigned WK_LENGTH = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sha256_msg_schedule_if.slave  bus
);
  import sha256_pkg::*;

  localparam int unsigned IDX_W = $clog2(WK_LENGTH);
  localparam int unsigned WIN   = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WK_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_GEN = IDX_W'(WK_LENGTH - WIN - 1);

  sched_state_t      r_state;
  logic [WORD_W-1:0] r_win [WIN];
  logic [IDX_W-1:0]  r_index;
  logic              r_in_ready;
  logic              r_valid;
  logic              r_done;
  logic [WORD_W-1:0] w_next;
  logic              w_hs;

`ifdef SHA_WVEC_OUT_EN
  logic [WK_LENGTH*WORD_W-1:0] r_wvec;
  logic                        r_wvec_ok;
`endif

  sha256_sched_word u_word (
    .i_w14 (r_win[14]),
    .i_w9  (r_win[9]),
    .i_w1  (r_win[1]),
    .i_w0  (r_win[0]),
    .o_w16 (w_next)
  );

  assign w_hs = r_valid & bus.w_ready;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_in_ready <= 1'b1;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      for (int unsigned i = 0; i < WIN; i++) r_win[i] <= '0;
`ifdef SHA_WVEC_OUT_EN
      r_wvec     <= '0;
      r_wvec_ok  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            for (int unsigned i = 0; i < WIN; i++)
              r_win[i] <= bus.block_in[BLOCK_W-1-WORD_W*i -: WORD_W];
            r_index    <= '0;
            r_in_ready <= 1'b0;
            r_valid    <= 1'b1;
            r_state    <= RUN;
`ifdef SHA_WVEC_OUT_EN
            r_wvec     <= '0;
            r_wvec_ok  <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (w_hs) begin
`ifdef SHA_WVEC_OUT_EN
            r_wvec[WORD_W*r_index +: WORD_W] <= r_win[0];
`endif
            // The final word is held in win[0] rather than shifted out.
            if (r_index == LAST_IDX) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
`ifdef SHA_WVEC_OUT_EN
              r_wvec_ok <= 1'b1;
`endif
            end else begin
              for (int unsigned i = 0; i < WIN - 1; i++) r_win[i] <= r_win[i+1];
              r_win[WIN-1] <= (r_index <= LAST_GEN) ? w_next : '0;
              r_index      <= r_index + 1'b1;
            end
          end
        end
        DONE: begin
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.w_valid  = r_valid;
  assign bus.w_out    = r_win[0];
  assign bus.w_index  = r_index;
  assign bus.w_last   = r_valid & (r_index == LAST_IDX);
  assign bus.done     = r_done;
`ifdef SHA_WVEC_OUT_EN
  assign bus.w_vector    = r_wvec;
  assign bus.w_vector_ok = r_wvec_ok;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule; covers the W-vector outputs when
// SHA_WVEC_OUT_EN is defined.
module tb_sha256_msg_schedule;
  import sha256_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  sha256_msg_schedule_if bus ();

  sha256_msg_schedule #(.WK_LENGTH(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit          ones;
    int unsigned idx;
    logic [31:0] w;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_w [64];
  logic [31:0] cap   [64];
  vec_t        tab   [8];

  logic [511:0] blk_abc  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
  logic [511:0] blk_ones = {16{32'hFFFFFFFF}};
  logic [511:0] blk_alt  = {16{32'hDEADBEEF}};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      exp_w[t] = (ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
               + exp_w[t-7]
               + (ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
               + exp_w[t-16];
  endtask

  task automatic check_table(input bit ones);
    for (int i = 0; i < 8; i++)
      if (tab[i].ones == ones) chk($sformatf("tab_w%0d", tab[i].idx), cap[tab[i].idx], tab[i].w);
  endtask

  task automatic run_stream(input logic [511:0] blk, input int unsigned stall_pct,
                            input bit poke_start, input int abort_at);
    int unsigned cnt = 0;
    int unsigned cyc = 0;
    int unsigned f0  = n_fail;
    chk("in_ready_idle", bus.in_ready, 1);
    bus.block_in = blk;
    bus.start    = 1'b1;
    bus.w_ready  = 1'b0;
    @(negedge clock);
    bus.start    = 1'b0;
    bus.block_in = blk_alt;
    chk("latency_valid", bus.w_valid, 1);
`ifdef SHA_WVEC_OUT_EN
    chk("wvec_ok_cleared", bus.w_vector_ok, 0);
    chk("wvec_cleared", (bus.w_vector == '0), 1);
`endif
    while (cnt < 64) begin
      if (cyc >= 2000) begin
        chk("stream_timeout", cnt, 64);
        return;
      end
      chk("w_valid", bus.w_valid, 1);
      chk("w_index", bus.w_index, cnt);
      chk("w_out", bus.w_out, exp_w[cnt]);
      chk("w_last", bus.w_last, (cnt == 63));
      chk("done_early", bus.done, 0);
      chk("in_ready_run", bus.in_ready, 0);
      if (n_fail != f0) return;
      if (abort_at == int'(cnt)) begin
        reset_n     = 1'b0;
        bus.w_ready = 1'b1;
        @(negedge clock);
        chk("abort_valid", bus.w_valid, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_index", bus.w_index, 0);
        chk("abort_out", bus.w_out, 0);
`ifdef SHA_WVEC_OUT_EN
        chk("abort_wvec_ok", bus.w_vector_ok, 0);
`endif
        reset_n     = 1'b1;
        bus.w_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          chk("abort_no_done", bus.done, 0);
          @(negedge clock);
        end
        return;
      end
      if (poke_start && cyc == 3) begin
        bus.start    = 1'b1;
        bus.block_in = blk_alt;
      end
      bus.w_ready = ($urandom_range(99) >= stall_pct);
      if (bus.w_ready) begin
        cap[cnt] = bus.w_out;
        cnt++;
      end
      @(negedge clock);
      cyc++;
      bus.start = 1'b0;
    end
    bus.w_ready = 1'b0;
    chk("done_pulse", bus.done, 1);
    chk("done_valid", bus.w_valid, 0);
    chk("done_last", bus.w_last, 0);
    chk("done_in_ready", bus.in_ready, 0);
`ifdef SHA_WVEC_OUT_EN
    chk("wvec_ok_with_done", bus.w_vector_ok, 1);
`endif
    @(negedge clock);
    chk("done_one_cycle", bus.done, 0);
    chk("idle_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tab[0] = '{1'b0, 0,  32'h61626380};
    tab[1] = '{1'b0, 15, 32'h00000018};
    tab[2] = '{1'b0, 16, 32'h61626380};
    tab[3] = '{1'b0, 17, 32'h000F0000};
    tab[4] = '{1'b0, 18, 32'h7DA86405};
    tab[5] = '{1'b0, 63, 32'h12B1EDEB};
    tab[6] = '{1'b1, 16, 32'h203FFFFC};
    tab[7] = '{1'b1, 17, 32'h203FFFFC};

    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.block_in = '0;
    bus.w_ready  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_valid", bus.w_valid, 0);
    chk("rst_out", bus.w_out, 0);
    chk("rst_index", bus.w_index, 0);
    chk("rst_last", bus.w_last, 0);
    chk("rst_done", bus.done, 0);
`ifdef SHA_WVEC_OUT_EN
    chk("rst_wvec", (bus.w_vector == '0), 1);
    chk("rst_wvec_ok", bus.w_vector_ok, 0);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    build_model(blk_abc);
    run_stream(blk_abc, 0, 1'b0, -1);
    check_table(1'b0);
`ifdef SHA_WVEC_OUT_EN
    repeat (3) @(negedge clock);
    chk("wvec_w0", bus.w_vector[31:0], 32'h61626380);
    chk("wvec_w63", bus.w_vector[2047:2016], 32'h12B1EDEB);
    chk("wvec_ok_hold", bus.w_vector_ok, 1);
    for (int t = 0; t < 64; t++) chk("wvec_model", bus.w_vector[32*t +: 32], exp_w[t]);
`endif

    run_stream(blk_abc, 50, 1'b0, -1);
    run_stream(blk_abc, 0, 1'b1, -1);
    run_stream(blk_abc, 0, 1'b0, 20);
    run_stream(blk_abc, 0, 1'b0, -1);

    build_model(blk_ones);
    run_stream(blk_ones, 30, 1'b0, -1);
    check_table(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
